// File: rtl/rgb2i_pkg.sv
// rtl/rgb2i_pkg.sv - shared types and constants for the RGB-to-intensity arbiter
package rgb2i_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam int RGB_W  = 24;
    localparam int I_W    = 10;
    localparam int CNT_W  = 12;

    // Luma weights scaled by 2^SHIFT; they sum to exactly 1024
    localparam int COEF_R = 306;
    localparam int COEF_G = 601;
    localparam int COEF_B = 117;
    localparam int SHIFT  = 10;

endpackage

// File: rtl/rgb2i_arb_if.sv
// rtl/rgb2i_arb_if.sv - FWFT source/sink bundle between the arbiter and its FIFOs
interface rgb2i_arb_if;
    import rgb2i_pkg::*;

    logic             rgb0_empty_n;
    logic             rgb0_read;
    logic [RGB_W-1:0] rgb0_dout;
    logic             rgb1_empty_n;
    logic             rgb1_read;
    logic [RGB_W-1:0] rgb1_dout;
    logic             i_full_n;
    logic             i_write;
    logic [I_W-1:0]   i_din;
    logic             i_src;
    logic             burst_done;

    modport master (
        input  rgb0_empty_n, rgb0_dout, rgb1_empty_n, rgb1_dout, i_full_n,
        output rgb0_read, rgb1_read, i_write, i_din, i_src, burst_done
    );

    modport slave (
        output rgb0_empty_n, rgb0_dout, rgb1_empty_n, rgb1_dout, i_full_n,
        input  rgb0_read, rgb1_read, i_write, i_din, i_src, burst_done
    );

endinterface

// File: rtl/rgb2i_luma.sv
// rtl/rgb2i_luma.sv - combinational BGR888 to 8-bit intensity (10-bit bus)
module rgb2i_luma
    import rgb2i_pkg::*;
(
    input  logic [RGB_W-1:0] rgb,
    output logic [I_W-1:0]   i
);

    logic [17:0] sum;

    // 1024*255 fits in 18 bits, so the unsigned sum never overflows
    assign sum = 18'(COEF_R) * 18'(rgb[7:0])
               + 18'(COEF_G) * 18'(rgb[15:8])
               + 18'(COEF_B) * 18'(rgb[23:16]);

    assign i = I_W'(sum >> SHIFT);

endmodule

// File: rtl/rgb2i_arb.sv
// rtl/rgb2i_arb.sv - two-source burst arbiter feeding one intensity sink
// Optional per-source burst counters with RGB2I_ARB_STATS_EN.
module rgb2i_arb
    import rgb2i_pkg::*;
#(
    parameter int BURST_LEN = 640
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_ce,
    rgb2i_arb_if.master bus
`ifdef RGB2I_ARB_STATS_EN
    ,
    output logic [31:0] burst_cnt0,
    output logic [31:0] burst_cnt1
`endif
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             last_grant, last_grant_nx;
    logic             sel;
    logic             src_ready;
    logic             xfer;
    logic             last_beat;
    logic [RGB_W-1:0] pix;

    assign sel       = (state == GRANT1);
    assign src_ready = sel ? bus.rgb1_empty_n : bus.rgb0_empty_n;
    assign pix       = sel ? bus.rgb1_dout : bus.rgb0_dout;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else if (ap_ce) begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_grant <= last_grant_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_grant_nx = last_grant;
        xfer          = 1'b0;
        last_beat     = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the source that did not own the previous burst wins
                if (bus.rgb0_empty_n && bus.rgb1_empty_n)
                    state_nx = last_grant ? GRANT0 : GRANT1;
                else if (bus.rgb0_empty_n)
                    state_nx = GRANT0;
                else if (bus.rgb1_empty_n)
                    state_nx = GRANT1;
            end
            GRANT0, GRANT1: begin
                xfer = src_ready && bus.i_full_n && ap_ce && !ap_rst;
                if (xfer) begin
                    if (cnt == LAST_BEAT) begin
                        last_beat     = 1'b1;
                        cnt_nx        = '0;
                        last_grant_nx = sel;
                        state_nx      = IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.rgb0_read  = xfer && !sel;
    assign bus.rgb1_read  = xfer && sel;
    assign bus.i_write    = xfer;
    assign bus.burst_done = last_beat;
    assign bus.i_src      = sel;

    rgb2i_luma u_luma (
        .rgb (pix),
        .i   (bus.i_din)
    );

`ifdef RGB2I_ARB_STATS_EN
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            burst_cnt0 <= '0;
            burst_cnt1 <= '0;
        end else if (last_beat) begin
            if (sel)
                burst_cnt1 <= burst_cnt1 + 32'd1;
            else
                burst_cnt0 <= burst_cnt0 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rgb2i_arb.sv
// tb/tb_rgb2i_arb.sv - bench for rgb2i_arb with burst lengths 4, 2 and 8
module tb_rgb2i_arb;

    logic ap_clk = 1'b0;
    logic ap_rst;
    logic ap_ce;

    always #5 ap_clk = ~ap_clk;

    rgb2i_arb_if bi4 ();
    rgb2i_arb_if bi2 ();
    rgb2i_arb_if bi8 ();

`ifdef RGB2I_ARB_STATS_EN
    logic [31:0] bc0 [3];
    logic [31:0] bc1 [3];
`endif

    rgb2i_arb #(.BURST_LEN(4)) u4 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .bus(bi4)
`ifdef RGB2I_ARB_STATS_EN
        , .burst_cnt0(bc0[0]), .burst_cnt1(bc1[0])
`endif
    );
    rgb2i_arb #(.BURST_LEN(2)) u2 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .bus(bi2)
`ifdef RGB2I_ARB_STATS_EN
        , .burst_cnt0(bc0[1]), .burst_cnt1(bc1[1])
`endif
    );
    rgb2i_arb #(.BURST_LEN(8)) u8 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .bus(bi8)
`ifdef RGB2I_ARB_STATS_EN
        , .burst_cnt0(bc0[2]), .burst_cnt1(bc1[2])
`endif
    );

    // {rgb0_read, rgb1_read, i_write, burst_done} per DUT
    logic [3:0] strb [3];
    logic [9:0] dino [3];
    logic       srco [3];

    assign strb[0] = {bi4.rgb0_read, bi4.rgb1_read, bi4.i_write, bi4.burst_done};
    assign strb[1] = {bi2.rgb0_read, bi2.rgb1_read, bi2.i_write, bi2.burst_done};
    assign strb[2] = {bi8.rgb0_read, bi8.rgb1_read, bi8.i_write, bi8.burst_done};
    assign dino[0] = bi4.i_din;
    assign dino[1] = bi2.i_din;
    assign dino[2] = bi8.i_din;
    assign srco[0] = bi4.i_src;
    assign srco[1] = bi2.i_src;
    assign srco[2] = bi8.i_src;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] R0   = 4'b1010;
    localparam logic [3:0] R0D  = 4'b1011;
    localparam logic [3:0] R1   = 4'b0110;
    localparam logic [3:0] R1D  = 4'b0111;

    typedef struct {
        int          dut;
        logic        rst, ce, e0, e1, full;
        logic [23:0] d0, d1;
        logic [3:0]  want;
        logic [9:0]  din;
        logic        src;
    } row_t;

    row_t rows[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [9:0] luma(logic [23:0] p);
        int s;
        s = 306 * int'(p[7:0]) + 601 * int'(p[15:8]) + 117 * int'(p[23:16]);
        return 10'(s / 1024);
    endfunction

    task automatic add(int dut, logic rst, logic ce, logic e0, logic e1, logic full,
                       logic [23:0] d0, logic [23:0] d1, logic [3:0] want,
                       logic [9:0] din, logic src);
        row_t r;
        r.dut = dut; r.rst = rst; r.ce = ce; r.e0 = e0; r.e1 = e1; r.full = full;
        r.d0 = d0; r.d1 = d1; r.want = want; r.din = din; r.src = src;
        rows.push_back(r);
    endtask

    task automatic addn(int n, int dut, logic rst, logic ce, logic e0, logic e1, logic full,
                        logic [23:0] d0, logic [23:0] d1, logic [3:0] want,
                        logic [9:0] din, logic src);
        for (int k = 0; k < n; k++) add(dut, rst, ce, e0, e1, full, d0, d1, want, din, src);
    endtask

    task automatic drive(logic rst, logic ce, logic e0, logic e1, logic full,
                         logic [23:0] d0, logic [23:0] d1);
        ap_rst = rst;
        ap_ce  = ce;
        bi4.rgb0_empty_n = e0; bi4.rgb1_empty_n = e1; bi4.i_full_n = full;
        bi4.rgb0_dout = d0;    bi4.rgb1_dout = d1;
        bi2.rgb0_empty_n = e0; bi2.rgb1_empty_n = e1; bi2.i_full_n = full;
        bi2.rgb0_dout = d0;    bi2.rgb1_dout = d1;
        bi8.rgb0_empty_n = e0; bi8.rgb1_empty_n = e1; bi8.i_full_n = full;
        bi8.rgb0_dout = d0;    bi8.rgb1_dout = d1;
    endtask

    task automatic check(string tag, int idx, int d, logic [3:0] want,
                         logic [9:0] din, logic src);
        checks++;
        if (strb[d] !== want) begin
            failures++;
            $display("FAIL %s strobes dut%0d step%0d: got %b want %b", tag, d, idx, strb[d], want);
        end
        if (want[1]) begin
            checks++;
            if (dino[d] !== din || srco[d] !== src) begin
                failures++;
                $display("FAIL %s data dut%0d step%0d: got din=%h src=%0d want din=%h src=%0d",
                         tag, d, idx, dino[d], srco[d], din, src);
            end
        end
    endtask

    // Reference model: who owns the sink, beats already moved, previous owner
    int bl [3] = '{4, 2, 8};
    int owner [3];
    int beats [3];
    int prev [3];
    int nburst [3][2];

    initial begin
        logic [23:0] pa, pb, pc, pd, pe;
        logic        rst, ce, e0, e1, full;
        logic [23:0] d0, d1;
        logic [3:0]  want;
        logic [9:0]  edin;
        logic        xf;

        pa = 24'hFFFFFF; pb = 24'h204080; pc = 24'h0000FF; pd = 24'h123456; pe = 24'h000000;

        // Full-white burst of 4 from source 0
        add (0, 1, 1, 0, 0, 1, pa, pe, NONE, 10'h0, 0);
        add (0, 0, 1, 1, 0, 1, pa, pe, NONE, 10'h0, 0);
        addn(3, 0, 0, 1, 1, 0, 1, pa, pe, R0, 10'h0FF, 0);
        add (0, 0, 1, 1, 0, 1, pa, pe, R0D, 10'h0FF, 0);
        add (0, 0, 1, 1, 0, 1, pa, pe, NONE, 10'h0, 0);
        // Both sources busy, bursts of 2 alternate with one idle gap
        add (1, 1, 1, 0, 0, 1, pb, pc, NONE, 10'h0, 0);
        for (int k = 0; k < 3; k++) begin
            add(1, 0, 1, 1, 1, 1, pb, pc, NONE, 10'h0, 0);
            add(1, 0, 1, 1, 1, 1, pb, pc, (k == 1) ? R1 : R0, (k == 1) ? 10'd76 : 10'd79, k == 1);
            add(1, 0, 1, 1, 1, 1, pb, pc, (k == 1) ? R1D : R0D, (k == 1) ? 10'd76 : 10'd79, k == 1);
        end
        // Sink stalls 5 cycles inside a burst of 8
        add (2, 1, 1, 0, 0, 1, pd, pe, NONE, 10'h0, 0);
        add (2, 0, 1, 1, 0, 1, pd, pe, NONE, 10'h0, 0);
        addn(3, 2, 0, 1, 1, 0, 1, pd, pe, R0, 10'h03A, 0);
        addn(5, 2, 0, 1, 1, 0, 0, pd, pe, NONE, 10'h0, 0);
        addn(4, 2, 0, 1, 1, 0, 1, pd, pe, R0, 10'h03A, 0);
        add (2, 0, 1, 1, 0, 1, pd, pe, R0D, 10'h03A, 0);
        add (2, 0, 1, 0, 0, 1, pd, pe, NONE, 10'h0, 0);
        // Reset after 3 beats; a fresh 8-beat burst follows, source 0 wins the tie
        add (2, 1, 0, 0, 0, 1, pd, pc, NONE, 10'h0, 0);
        add (2, 0, 1, 1, 1, 1, pd, pc, NONE, 10'h0, 0);
        addn(3, 2, 0, 1, 1, 1, 1, pd, pc, R0, 10'h03A, 0);
        add (2, 1, 1, 1, 1, 1, pd, pc, NONE, 10'h0, 0);
        add (2, 0, 1, 1, 1, 1, pd, pc, NONE, 10'h0, 0);
        addn(7, 2, 0, 1, 1, 1, 1, pd, pc, R0, 10'h03A, 0);
        add (2, 0, 1, 1, 1, 1, pd, pc, R0D, 10'h03A, 0);
        add (2, 0, 1, 1, 1, 1, pd, pc, NONE, 10'h0, 0);
        // Clock enable low in IDLE and mid-burst freezes everything
        add (0, 1, 1, 0, 0, 1, pb, pe, NONE, 10'h0, 0);
        add (0, 0, 0, 1, 0, 1, pb, pe, NONE, 10'h0, 0);
        add (0, 0, 1, 1, 0, 1, pb, pe, NONE, 10'h0, 0);
        addn(2, 0, 0, 1, 1, 0, 1, pb, pe, R0, 10'd79, 0);
        addn(3, 0, 0, 0, 1, 0, 1, pb, pe, NONE, 10'h0, 0);
        add (0, 0, 1, 1, 0, 1, pb, pe, R0, 10'd79, 0);
        add (0, 0, 1, 1, 0, 1, pb, pe, R0D, 10'd79, 0);
        add (0, 0, 1, 0, 0, 1, pb, pe, NONE, 10'h0, 0);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0);
        @(posedge ap_clk); #1;

        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].ce, rows[i].e0, rows[i].e1, rows[i].full, rows[i].d0, rows[i].d1);
            @(negedge ap_clk);
            check("table", i, rows[i].dut, rows[i].want, rows[i].din, rows[i].src);
            @(posedge ap_clk); #1;
        end

`ifdef RGB2I_ARB_STATS_EN
        checks++;
        if (bc0[0] !== 32'd1 || bc1[0] !== 32'd0) begin
            failures++;
            $display("FAIL stats_ce: got cnt0=%0d cnt1=%0d want cnt0=1 cnt1=0", bc0[0], bc1[0]);
        end
`endif

        // Randomized run against the reference model, all three burst lengths
        for (int c = 0; c < 3000; c++) begin
            rst  = (c == 0) || ($urandom_range(0, 99) < 2);
            ce   = $urandom_range(0, 99) < 85;
            e0   = $urandom_range(0, 99) < 70;
            e1   = $urandom_range(0, 99) < 70;
            full = $urandom_range(0, 99) < 75;
            d0   = 24'($urandom);
            d1   = 24'($urandom);
            drive(rst, ce, e0, e1, full, d0, d1);
            @(negedge ap_clk);
            for (int d = 0; d < 3; d++) begin
                want = NONE;
                edin = '0;
                xf   = 1'b0;
                if (!rst && owner[d] >= 0) begin
                    xf = ce && full && ((owner[d] == 0) ? e0 : e1);
                    if (xf) begin
                        want = (owner[d] == 0) ? R0 : R1;
                        want[0] = (beats[d] == bl[d] - 1);
                        edin = luma((owner[d] == 0) ? d0 : d1);
                    end
                end
                check("random", c, d, want, edin, owner[d] == 1);
                if (rst) begin
                    owner[d] = -1; beats[d] = 0; prev[d] = 1;
                    nburst[d][0] = 0; nburst[d][1] = 0;
                end else if (ce) begin
                    if (owner[d] < 0) begin
                        if (e0 && e1)  owner[d] = 1 - prev[d];
                        else if (e0)   owner[d] = 0;
                        else if (e1)   owner[d] = 1;
                    end else if (xf) begin
                        beats[d]++;
                        if (beats[d] == bl[d]) begin
                            nburst[d][owner[d]]++;
                            prev[d]  = owner[d];
                            owner[d] = -1;
                            beats[d] = 0;
                        end
                    end
                end
            end
            @(posedge ap_clk); #1;
        end

`ifdef RGB2I_ARB_STATS_EN
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bc0[d] !== 32'(nburst[d][0]) || bc1[d] !== 32'(nburst[d][1])) begin
                failures++;
                $display("FAIL stats_rand dut%0d: got cnt0=%0d cnt1=%0d want cnt0=%0d cnt1=%0d",
                         d, bc0[d], bc1[d], nburst[d][0], nburst[d][1]);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb2i_arb.md
RGB2I_ARB -- requirements
Module: rgb2i_arb

Interface
REQ-001 SHALL have parameter BURST_LEN, default 640, the number of pixels per granted burst (one video line), legal range 1..4095.
REQ-002 SHALL have port ap_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ap_ce, input, 1 bit: clock enable; when low, no transfer, state change or counter change.
REQ-005 SHALL have ports rgb0_empty_n (input, 1), rgb0_read (output, 1), rgb0_dout (input, 24): FWFT source 0, B[23:16] G[15:8] R[7:0].
REQ-006 SHALL have ports rgb1_empty_n (input, 1), rgb1_read (output, 1), rgb1_dout (input, 24): FWFT source 1, same packing.
REQ-007 SHALL have ports i_full_n (input, 1), i_write (output, 1), i_din (output, 10): FWFT intensity sink.
REQ-008 SHALL have port i_src, output, 1 bit: index of the source whose pixel is on i_din, valid while i_write=1.
REQ-009 SHALL have port burst_done, output, 1 bit: one-cycle pulse on the cycle of the last beat of a burst.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT0, GRANT1, plus a 1-bit last_grant register and a 12-bit beat counter.
REQ-011 SHALL, in IDLE with ap_ce=1, go to GRANT0 if only rgb0_empty_n=1, to GRANT1 if only rgb1_empty_n=1, and to the source not equal to last_grant if both are 1; it stays in IDLE if neither is 1.
REQ-012 SHALL treat a transfer as: state GRANTk, rgbk_empty_n=1, i_full_n=1, ap_ce=1, ap_rst=0; on a transfer rgbk_read=1 and i_write=1 in the same cycle, combinationally.
REQ-013 SHALL hold rgbk_read=0 for the source not granted, and drive all read/write strobes low in IDLE.
REQ-014 SHALL compute i_din = (306*R + 601*G + 117*B) >> 10 from the granted source's dout, using an 18-bit unsigned sum with no rounding; the result is at most 255 and i_din[9:8] is always 0.
REQ-015 SHALL have zero cycles of latency: i_din and i_src are combinational from the granted source.
REQ-016 SHALL increment the beat counter on each transfer; on the transfer where counter = BURST_LEN-1 it SHALL pulse burst_done, clear the counter, set last_grant to k and return to IDLE.
REQ-017 SHALL keep the grant while stalled: if the source is empty or the sink is full mid-burst, the state and counter hold and the grant is not released.
REQ-018 SHALL, with BURST_LEN=1, do exactly one transfer per grant and then arbitrate again through IDLE.
REQ-019 SHALL give a minimum arbitration gap of exactly one IDLE cycle between bursts.

Reset
REQ-020 SHALL, on ap_rst=1 at a clock edge and regardless of ap_ce, set the state to IDLE, the counter to 0 and last_grant to 1, so that source 0 wins the first tie.
REQ-021 SHALL force rgb0_read, rgb1_read, i_write and burst_done to 0 combinationally while ap_rst=1; i_din and i_src are don't-care.
REQ-022 SHALL abandon a burst in progress when reset arrives mid-burst; the partial beat count is discarded.

Configuration
REQ-023 SHALL, when macro RGB2I_ARB_STATS_EN is defined, add outputs burst_cnt0 and burst_cnt1 (32 bits each), counting completed bursts per source; they clear on reset and wrap from 0xFFFFFFFF to 0.
REQ-024 SHALL, without RGB2I_ARB_STATS_EN, have neither the ports nor the logic; all other behaviour is identical.

Structure
REQ-025 SHALL take from shared package rgb2i_pkg: the state enum, the coefficients COEF_R=306, COEF_G=601, COEF_B=117, SHIFT=10, and the RGB_W=24 and I_W=10 widths.
REQ-026 SHALL instantiate one combinational sub-module rgb2i_luma (24-bit rgb in, 10-bit i out) on the muxed source data.

Verification
REQ-027 SHALL cover: rgb0 data 0xFFFFFF, rgb1 empty, BURST_LEN=4 -> four writes of i_din=0x0FF with i_src=0, burst_done on the 4th write, then IDLE.
REQ-028 SHALL cover: both sources always non-empty, BURST_LEN=2 -> grants alternate 0,0,1,1,0,0 with one idle cycle between pairs.
REQ-029 SHALL cover: i_full_n=0 for 5 cycles mid-burst (BURST_LEN=8) -> no read or write during the stall, grant held, 8 total writes, no drop or duplicate.
REQ-030 SHALL cover: rgb0 pixel R=0x80, G=0x40, B=0x20 -> i_din=(39168+38464+3744)>>10=79 (0x04F).
REQ-031 SHALL cover: ap_rst=1 after 3 of 8 beats -> strobes low that cycle; the next grant starts a fresh 8-beat burst and source 0 wins the tie.
REQ-032 SHALL cover: ap_ce=0 for 3 cycles mid-burst -> no strobes and no state change; with RGB2I_ARB_STATS_EN, burst_cnt0 increments once per completed burst.
